memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Round-robin arbiter that shares the single RAM port between `CPUS` cache controllers, each with an instruction and a data port. It sits between the per-core icache/dcache request lines and RAM. It latches one request at a time, drives RAM from the granted port until RAM reports `ACCESS`, then releases the wait for that port. It replaces the single-core pass-through routing for multicore builds and carries no coherence logic.

## Interface
Parameters:
- `CPUS`, default 2: number of requesting cores, 1 to 4; index width is `IW = max(1,$clog2(CPUS))`.

Ports (types from `cpu_types_pkg`; `word_t` is 32 bits):
- `CLK`  in  1  system clock; all state on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `iREN[CPUS]`  in  1 each  instruction read request.
- `dREN[CPUS]`, `dWEN[CPUS]`  in  1 each  data read / write request.
- `iaddr[CPUS]`, `daddr[CPUS]`, `dstore[CPUS]`  in  word_t each  request address and store data.
- `iwait[CPUS]`, `dwait[CPUS]`  out  1 each  low for exactly the completing cycle of that port.
- `iload[CPUS]`, `dload[CPUS]`  out  word_t each  `ramload` on the granted port, else 0.
- `ramREN`, `ramWEN`  out  1  RAM enables; never both high.
- `ramaddr`, `ramstore`  out  word_t  RAM address and write data; `ramstore` is 0 unless `ramWEN` is high.
- `ramload`  in  word_t  RAM read data.
- `ramstate`  in  ramstate_t  FREE / BUSY / ACCESS / ERROR.

## Operation
- State machine has two states, IDLE and GRANT.
- Registers:
  - `owner` (IW bits)
  - `kind`: IFETCH, DREAD or DWRITE
  - `rr` (IW bits): next-priority core
- Candidate for a core: `dWEN` beats `dREN`, which beats `iREN`.
- IDLE:
  - No RAM enables are driven.
  - If any core has a candidate, pick the first requesting core scanning from `rr` upward, modulo `CPUS`.
  - Latch `owner` and `kind`, then go to GRANT.
- GRANT:
  - Drive `ramaddr` from the owner's port address.
  - For DWRITE, drive `ramWEN=1` and `ramstore=dstore[owner]`; otherwise drive `ramREN=1`.
  - If `ramstate==ACCESS` and the latched request is still asserted:
    - drive the owner's matching wait low this cycle;
    - set `rr <= owner+1` (wraps to 0);
    - go to IDLE.
  - If the owner deasserts the latched enable, abort: enables drop combinationally that cycle, no wait goes low, state goes to IDLE, and `rr` is unchanged.
  - `ERROR`, `BUSY` and `FREE` hold GRANT with waits high.
- All non-owner waits stay high. Other ports of the owning core stay high too.
- Loads: the owner's matching load equals `ramload` while in GRANT; every other load is 0.
- Requesters hold address, data and enable stable until their wait goes low. This is the standard cache-side handshake.

## Timing
- Reset values:
  - state IDLE, `owner=0`, `kind=IFETCH`, `rr=0`;
  - `ramREN=ramWEN=0`, `ramaddr=ramstore=0`;
  - all waits 1, all loads 0.
- `RST` sampled high mid-transaction returns everything to reset values next edge. RAM enables drop that edge with no completion.
- Latency: request seen in IDLE at cycle 0; RAM enable high in cycle 1; completion in the first GRANT cycle with `ACCESS`. Minimum 2 cycles request-to-wait-low.
- Back-to-back: after completion, IDLE lasts one cycle. A held request by a different core wins at that IDLE if it is next in `rr` order.
- Simultaneous requests in IDLE: exactly one grant. Remaining requests wait; no request is lost while held.
- Starvation bound: a held request is granted within `CPUS` transactions.
- `CPUS=1`: `rr` stays 0; behaves as the prioritised single-core router plus one IDLE cycle.

## Configuration
- `MEMARB_DATA_FIRST_EN` defined:
  - In IDLE, any core's data request (`dWEN`/`dREN`) beats every instruction request system-wide.
  - Round-robin applies first among data requesters, then among instruction requesters.
  - `rr` advances on every completion.
- `MEMARB_DATA_FIRST_EN` undefined: pure per-core round-robin as in Operation. An instruction request of core `rr` beats a data request of another core.

## Test plan
- Reset: assert `RST` 2 cycles with all requests high → `ramREN=ramWEN=0`, all waits 1, `rr=0`; first grant goes to core 0 in the cycle after release.
- Single read: core 1 `dREN`, `daddr=0x40`, RAM `ACCESS` on 3rd GRANT cycle with `ramload=0xDEADBEEF` → `ramREN=1`, `ramaddr=0x40`, `dwait[1]` low one cycle with `dload[1]=0xDEADBEEF`.
- Contention: both cores hold `iREN` from reset, RAM gives ACCESS every 2nd cycle → grants alternate 0,1,0,1; each `iwait` pulses low alternately.
- Intra-core priority: core 0 `iREN`, `dWEN` (`dstore=0x1234`, `daddr=0x80`) together → write first: `ramWEN=1`, `ramstore=0x1234`; then `iaddr` read on next grant.
- Abort and error: core 0 drops `dREN` in GRANT → enables drop that cycle, no wait pulse, `rr` still 0. `ramstate=ERROR` for 5 cycles → waits stay 1, grant held.
- Macro on: `rr=0`, core 0 `iREN`, core 1 `dREN` → core 1 granted first. Macro off → core 0 granted first.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: shared types plus the cache-side request bus and single RAM port
// seen by memory_arbiter.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

interface memory_arbiter_if #(parameter int CPUS = 2);
  import cpu_types_pkg::*;
  logic [CPUS-1:0] iREN, dREN, dWEN, iwait, dwait;
  word_t iaddr [CPUS];
  word_t daddr [CPUS];
  word_t dstore [CPUS];
  word_t iload [CPUS];
  word_t dload [CPUS];
  logic ramREN, ramWEN;
  word_t ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  modport master (output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
                  input iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore);
  modport slave (input iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
                 output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore);
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sharing of one RAM port between CPUS icache/dcache pairs.
// Define MEMARB_DATA_FIRST_EN to let any data request beat every instruction request.
module memory_arbiter import cpu_types_pkg::*; #(parameter int CPUS = 2) (
  input logic CLK,
  input logic RST,
  memory_arbiter_if.slave bus
);
  localparam int IW = CPUS > 1 ? $clog2(CPUS) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  typedef enum logic [1:0] {IFETCH, DREAD, DWRITE} kind_t;
  state_t state;
  kind_t kind, pick_kind;
  logic [IW-1:0] owner, rr, pick, idx, rr_next;
  logic [CPUS-1:0] mask;
  logic found, held, gnt, done;
  word_t addr;
`ifdef MEMARB_DATA_FIRST_EN
  assign mask = |(bus.dREN | bus.dWEN) ? bus.dREN | bus.dWEN : bus.iREN;
`else
  assign mask = bus.dREN | bus.dWEN | bus.iREN;
`endif
  // first requester at or after rr, wrapping modulo CPUS
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int k = 0; k < CPUS; k++) begin
      idx = IW'((int'(rr) + k) % CPUS);
      if (!found && mask[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  assign pick_kind = bus.dWEN[pick] ? DWRITE : bus.dREN[pick] ? DREAD : IFETCH;
  assign held = kind == DWRITE ? bus.dWEN[owner] : kind == DREAD ? bus.dREN[owner] : bus.iREN[owner];
  assign gnt = state == GRANT && held;
  assign done = gnt && bus.ramstate == ACCESS;
  assign addr = kind == IFETCH ? bus.iaddr[owner] : bus.daddr[owner];
  assign bus.ramWEN = gnt && kind == DWRITE;
  assign bus.ramREN = gnt && kind != DWRITE;
  assign bus.ramaddr = gnt ? addr : '0;
  assign bus.ramstore = bus.ramWEN ? bus.dstore[owner] : '0;
  assign rr_next = owner == IW'(CPUS - 1) ? '0 : owner + 1'b1;
  always_comb begin
    for (int c = 0; c < CPUS; c++) begin
      bus.iwait[c] = !(done && owner == IW'(c) && kind == IFETCH);
      bus.dwait[c] = !(done && owner == IW'(c) && kind != IFETCH);
      bus.iload[c] = state == GRANT && owner == IW'(c) && kind == IFETCH ? bus.ramload : '0;
      bus.dload[c] = state == GRANT && owner == IW'(c) && kind != IFETCH ? bus.ramload : '0;
    end
  end
  // a dropped enable aborts the grant without advancing rr
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      owner <= '0;
      kind <= IFETCH;
      rr <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        state <= GRANT;
        owner <= pick;
        kind <= pick_kind;
      end
    end else if (!held || done) begin
      state <= IDLE;
      if (done) rr <= rr_next;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus a randomized run against a transaction-level
// round-robin model of the arbiter.
module tb_memory_arbiter;
  import cpu_types_pkg::*;
  localparam int CPUS = 2;
  logic CLK = 1'b0, RST = 1'b1;
  int checks = 0, errors = 0, mrr = 0;
  memory_arbiter_if #(.CPUS(CPUS)) bus ();
  memory_arbiter #(.CPUS(CPUS)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;

  task automatic clr();
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
    for (int c = 0; c < CPUS; c++) begin
      bus.iaddr[c] = '0; bus.daddr[c] = '0; bus.dstore[c] = '0;
    end
    bus.ramstate = FREE; bus.ramload = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1; clr();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  function automatic int exp_owner();
    int best = -1;
`ifdef MEMARB_DATA_FIRST_EN
    for (int k = 0; k < CPUS; k++)
      if (best < 0 && (bus.dREN[(mrr + k) % CPUS] || bus.dWEN[(mrr + k) % CPUS])) best = (mrr + k) % CPUS;
    for (int k = 0; k < CPUS; k++)
      if (best < 0 && bus.iREN[(mrr + k) % CPUS]) best = (mrr + k) % CPUS;
`else
    for (int k = 0; k < CPUS; k++) begin
      int c = (mrr + k) % CPUS;
      if (best < 0 && (bus.iREN[c] || bus.dREN[c] || bus.dWEN[c])) best = c;
    end
`endif
    return best;
  endfunction

  task automatic raise();
    for (int c = 0; c < CPUS; c++) begin
      if (!bus.iREN[c] && $urandom_range(0, 3) == 0) begin bus.iREN[c] = 1'b1; bus.iaddr[c] = $urandom; end
      if (!bus.dREN[c] && $urandom_range(0, 3) == 0) begin bus.dREN[c] = 1'b1; bus.daddr[c] = $urandom; end
      if (!bus.dWEN[c] && $urandom_range(0, 3) == 0) begin
        bus.dWEN[c] = 1'b1; bus.daddr[c] = $urandom; bus.dstore[c] = $urandom;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.iREN = '1; bus.dREN = '1; bus.dWEN = '1;
    for (int c = 0; c < CPUS; c++) begin
      bus.iaddr[c] = 32'h1000 + c; bus.daddr[c] = 32'h2000 + c; bus.dstore[c] = 32'h3000 + c;
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin errors++; $display("FAIL reset_en: got %b want 00", {bus.ramREN, bus.ramWEN}); end
    checks++;
    if ({bus.ramaddr, bus.ramstore} !== 64'h0) begin errors++; $display("FAIL reset_bus: got %h/%h want 0/0", bus.ramaddr, bus.ramstore); end
    checks++;
    if ({bus.iwait, bus.dwait} !== 4'hf) begin errors++; $display("FAIL reset_wait: got %b want 1111", {bus.iwait, bus.dwait}); end
    for (int c = 0; c < CPUS; c++) begin
      checks++;
      if (bus.iload[c] !== 0 || bus.dload[c] !== 0) begin errors++; $display("FAIL reset_load%0d: got %h/%h want 0", c, bus.iload[c], bus.dload[c]); end
    end
    @(posedge CLK); #1 RST = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (!(bus.ramWEN === 1'b1 && bus.ramaddr === 32'h2000 && bus.ramstore === 32'h3000))
      begin errors++; $display("FAIL reset_first_grant: got wen=%b addr=%h store=%h want 1/2000/3000", bus.ramWEN, bus.ramaddr, bus.ramstore); end
    clr();
  endtask

  task automatic test_single_read();
    do_reset();
    bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h40;
    @(posedge CLK); #1;
    for (int g = 1; g <= 3; g++) begin
      if (g == 3) begin bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF; end
      @(negedge CLK);
      checks++;
      if (!(bus.ramREN === 1'b1 && bus.ramaddr === 32'h40)) begin errors++; $display("FAIL read_drive%0d: got ren=%b addr=%h want 1/40", g, bus.ramREN, bus.ramaddr); end
      checks++;
      if ({bus.iwait, bus.dwait} !== {2'b11, g == 3 ? 2'b01 : 2'b11}) begin errors++; $display("FAIL read_wait%0d: got %b", g, {bus.iwait, bus.dwait}); end
      if (g == 3) begin
        checks++;
        if (bus.dload[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL read_load: got %h want deadbeef", bus.dload[1]); end
      end
      @(posedge CLK); #1;
    end
    bus.dREN[1] = 1'b0; bus.ramstate = FREE;
    @(negedge CLK);
    checks++;
    if (!(bus.dwait[1] === 1'b1 && bus.ramREN === 1'b0)) begin errors++; $display("FAIL read_after: got dwait=%b ren=%b want 1/0", bus.dwait[1], bus.ramREN); end
  endtask

  task automatic test_contention();
    int q[$];
    do_reset();
    bus.iREN = 2'b11; bus.iaddr[0] = 32'h10; bus.iaddr[1] = 32'h20;
    for (int n = 0; n < 12; n++) begin
      bus.ramstate = n % 2 ? ACCESS : FREE;
      @(negedge CLK);
      if (bus.iwait !== 2'b11) q.push_back(bus.iwait[0] ? 1 : 0);
      @(posedge CLK); #1;
    end
    checks++;
    if (q.size() != 6) begin errors++; $display("FAIL contend_count: got %0d want 6", q.size()); end
    foreach (q[i]) begin
      checks++;
      if (q[i] != i % 2) begin errors++; $display("FAIL contend_order%0d: got core %0d want %0d", i, q[i], i % 2); end
    end
    clr();
  endtask

  task automatic test_priority();
    do_reset();
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h100;
    bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h80; bus.dstore[0] = 32'h1234;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (!(bus.ramWEN === 1'b1 && bus.ramREN === 1'b0 && bus.ramstore === 32'h1234 && bus.ramaddr === 32'h80))
      begin errors++; $display("FAIL prio_write: got wen=%b ren=%b store=%h addr=%h", bus.ramWEN, bus.ramREN, bus.ramstore, bus.ramaddr); end
    @(posedge CLK); #1 bus.ramstate = ACCESS;
    @(negedge CLK);
    checks++;
    if (!(bus.dwait[0] === 1'b0 && bus.iwait[0] === 1'b1)) begin errors++; $display("FAIL prio_wdone: got dwait=%b iwait=%b want 0/1", bus.dwait[0], bus.iwait[0]); end
    @(posedge CLK); #1 bus.dWEN[0] = 1'b0; bus.ramstate = FREE;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (!(bus.ramREN === 1'b1 && bus.ramaddr === 32'h100 && bus.ramstore === 32'h0))
      begin errors++; $display("FAIL prio_read: got ren=%b addr=%h store=%h want 1/100/0", bus.ramREN, bus.ramaddr, bus.ramstore); end
    clr();
  endtask

  task automatic test_abort_error();
    do_reset();
    bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h44;
    @(posedge CLK); #1 bus.ramstate = ERROR;
    repeat (5) begin
      @(negedge CLK);
      checks++;
      if (!(bus.ramREN === 1'b1 && {bus.iwait, bus.dwait} === 4'hf)) begin errors++; $display("FAIL error_hold: got ren=%b waits=%b want 1/1111", bus.ramREN, {bus.iwait, bus.dwait}); end
      @(posedge CLK); #1;
    end
    bus.dREN[0] = 1'b0; bus.ramstate = ACCESS;
    @(negedge CLK);
    checks++;
    if (!({bus.ramREN, bus.ramWEN} === 2'b00 && {bus.iwait, bus.dwait} === 4'hf)) begin errors++; $display("FAIL abort: got en=%b waits=%b want 00/1111", {bus.ramREN, bus.ramWEN}, {bus.iwait, bus.dwait}); end
    @(posedge CLK); #1 bus.ramstate = FREE;
    bus.iREN = 2'b11; bus.iaddr[0] = 32'h500; bus.iaddr[1] = 32'h600;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (bus.ramaddr !== 32'h500) begin errors++; $display("FAIL abort_rr: got addr %h want 500", bus.ramaddr); end
    RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin errors++; $display("FAIL mid_reset: got en=%b want 00", {bus.ramREN, bus.ramWEN}); end
    clr();
  endtask

  task automatic test_data_first();
    word_t want;
`ifdef MEMARB_DATA_FIRST_EN
    want = 32'h800;
`else
    want = 32'h700;
`endif
    do_reset();
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h700; bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h800;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (!(bus.ramREN === 1'b1 && bus.ramaddr === want)) begin errors++; $display("FAIL data_first: got ren=%b addr=%h want 1/%h", bus.ramREN, bus.ramaddr, want); end
    clr();
  endtask

  task automatic test_random();
    int e, k, dc, dk, idle_run, ncomp;
    logic [CPUS-1:0] eiw, edw;
    word_t ea;
    do_reset();
    mrr = 0; dc = -1; dk = 0; idle_run = 0; ncomp = 0;
    raise();
    for (int n = 0; n < 600; n++) begin
      bus.ramstate = $urandom_range(0, 2) == 0 ? ACCESS : ramstate_t'(2'($urandom_range(0, 3)));
      bus.ramload = $urandom;
      @(negedge CLK);
      e = exp_owner();
      checks++;
      if (bus.ramREN && bus.ramWEN) begin errors++; $display("FAIL rand_both_en at %0d", n); end
      if (e < 0 || !(bus.ramREN || bus.ramWEN)) begin
        idle_run = e < 0 ? 0 : idle_run + 1;
        checks++;
        if ({bus.iwait, bus.dwait} !== '1 || bus.ramstore !== 0) begin errors++; $display("FAIL rand_idle_out at %0d: waits=%b store=%h", n, {bus.iwait, bus.dwait}, bus.ramstore); end
        checks++;
        if (idle_run > 1) begin errors++; $display("FAIL rand_idle_len at %0d: got %0d idle cycles want <=1", n, idle_run); end
      end else begin
        idle_run = 0;
        k = bus.dWEN[e] ? 2 : bus.dREN[e] ? 1 : 0;
        ea = k == 0 ? bus.iaddr[e] : bus.daddr[e];
        checks++;
        if (bus.ramaddr !== ea || bus.ramWEN !== (k == 2)) begin errors++; $display("FAIL rand_grant at %0d: got addr=%h wen=%b want %h/%b (core %0d)", n, bus.ramaddr, bus.ramWEN, ea, k == 2, e); end
        checks++;
        if (bus.ramstore !== (k == 2 ? bus.dstore[e] : 32'h0)) begin errors++; $display("FAIL rand_store at %0d: got %h", n, bus.ramstore); end
        eiw = '1; edw = '1;
        if (bus.ramstate == ACCESS) begin
          if (k == 0) eiw[e] = 1'b0; else edw[e] = 1'b0;
        end
        checks++;
        if (bus.iwait !== eiw || bus.dwait !== edw) begin errors++; $display("FAIL rand_wait at %0d: got %b/%b want %b/%b", n, bus.iwait, bus.dwait, eiw, edw); end
        if (bus.ramstate == ACCESS) begin
          if (k < 2) begin
            checks++;
            if ((k == 0 ? bus.iload[e] : bus.dload[e]) !== bus.ramload) begin errors++; $display("FAIL rand_load at %0d: got %h want %h", n, k == 0 ? bus.iload[e] : bus.dload[e], bus.ramload); end
          end
          dc = e; dk = k; mrr = (e + 1) % CPUS; ncomp++;
        end
      end
      @(posedge CLK); #1;
      if (dc >= 0) begin
        if (dk == 0) bus.iREN[dc] = 1'b0; else if (dk == 1) bus.dREN[dc] = 1'b0; else bus.dWEN[dc] = 1'b0;
      end
      if (dc >= 0 || exp_owner() < 0) raise();
      dc = -1;
    end
    checks++;
    if (ncomp < 60) begin errors++; $display("FAIL rand_progress: got %0d completions want >=60", ncomp); end
    clr();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr();
    test_reset();
    test_single_read();
    test_contention();
    test_priority();
    test_abort_error();
    test_data_first();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
